mult_div_unit: RTL

//  Iterative MIPS multiply/divide unit with architectural HI/LO registers.

---
 rtl/mult_div_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative MIPS multiply/divide unit that owns the architectural HI/LO
// registers. A MULT/MULTU/DIV/DIVU launched from IDLE takes one iteration per
// clock for DATA_W clocks, then one FINISH clock that applies the sign fixup
// and writes HI/LO. The result is visible 33 clocks after the start edge.
// MTHI/MTLO writes are taken only while idle, and only when no op is starting.
//
// Optional feature: define FAST_MULT_EN to make MULT/MULTU skip the iterative
// loop. They then go straight to FINISH with a registered combinational
// product, so the result is visible one clock after the start edge.
// DIV/DIVU are iterative in both builds.
//
// Ports
//   clk          clock, rising-edge
//   reset_n      asynchronous active-low reset
//   start        launch op (sampled only while idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        multiplicand / dividend, also MTHI/MTLO data
//   src_b        multiplier / divisor
//   mthi_we      MTHI: HI <= src_a
//   mtlo_we      MTLO: LO <= src_a
//   busy         op in flight
//   done         one-cycle pulse, HI/LO just updated
//   div_by_zero  qualified by done; divisor was zero
//   hi, lo       architectural HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]    count;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*DATA_W-1:0] acc;
    // Holds the multiplicand magnitude (MUL) or the divisor magnitude (DIV).
    logic [DATA_W-1:0]   opnd;
    logic                is_div;
    logic                res_neg;
    logic                rem_neg;
    logic                b_zero;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                fast_mult;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W-1:0]   div_sub;
    logic                div_ok;
    logic [2*DATA_W-1:0] acc_step;

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   fin_hi, fin_lo;

    // Operand magnitudes. Signed ops work on |a| and |b|, and the signs are
    // put back at FINISH. 0x80000000 keeps its bit pattern, which is the
    // correct unsigned magnitude.
    always_comb begin
        a_neg = ~op[0] & src_a[DATA_W-1];
        b_neg = ~op[0] & src_b[DATA_W-1];
        mag_a = a_neg ? (-src_a) : src_a;
        mag_b = b_neg ? (-src_b) : src_b;
    end

`ifdef FAST_MULT_EN
    assign fast_mult = ~op[1];
`else
    assign fast_mult = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = fast_mult ? FINISH : RUN;
            RUN:     if (count == LAST_CNT) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // One iteration step.
    // MUL: conditionally add the multiplicand into the high half, then shift
    //      the whole accumulator right. The carry lands in the top bit.
    // DIV: restoring division. Shift the next dividend bit into the remainder
    //      and keep the subtraction only when it does not go negative. With a
    //      zero divisor every subtraction succeeds, so the quotient becomes
    //      all ones and the remainder becomes exactly |dividend|.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_ok    = (div_shift >= {1'b0, opnd});
        div_sub   = div_shift[DATA_W-1:0] - opnd;
        if (is_div)
            acc_step = {(div_ok ? div_sub : div_shift[DATA_W-1:0]), acc[DATA_W-2:0], div_ok};
        else
            acc_step = {mul_sum, acc[DATA_W-1:1]};
    end

    // Sign fixup applied at FINISH. The remainder takes the dividend's sign.
    // For a zero divisor this turns |dividend| back into src_a. LO is forced
    // to all ones in that case.
    always_comb begin
        prod_fix = res_neg ? (-acc) : acc;
        quot_fix = res_neg ? (-acc[DATA_W-1:0]) : acc[DATA_W-1:0];
        rem_fix  = rem_neg ? (-acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
        if (is_div) begin
            fin_hi = rem_fix;
            fin_lo = b_zero ? '1 : quot_fix;
        end else begin
            fin_hi = prod_fix[2*DATA_W-1:DATA_W];
            fin_lo = prod_fix[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            b_zero      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count   <= '0;
                        is_div  <= op[1];
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        b_zero  <= (src_b == '0);
                        if (op[1]) begin
                            acc  <= {{DATA_W{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
`ifdef FAST_MULT_EN
                            acc  <= {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`else
                            acc  <= {{DATA_W{1'b0}}, mag_b};
`endif
                            opnd <= mag_a;
                        end
                    end else begin
                        if (mthi_we) hi <= src_a;
                        if (mtlo_we) lo <= src_a;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FINISH: begin
                    hi          <= fin_hi;
                    lo          <= fin_lo;
                    done        <= 1'b1;
                    div_by_zero <= is_div & b_zero;
                end
                default: ;
            endcase
        end
    end

endmodule
